ps2_rx_frame: RTL and testbench
===============================

Name: ps2_rx_frame

Overview:
Upstream receive stage for the PS/2 keyboard path. Samples the raw keyb_clk/keyb_data lines, filters clock glitches, deserialises 11-bit PS/2 frames and checks start, parity and stop bits. Folds 0xE0/0xF0 prefixes into flags and hands one decoded key event per keystroke to the scan-code-to-digit/seven-segment display stage.

Parameters:
FILTER_LEN, 4, consecutive clk samples of a new keyb_clk level needed before the filtered clock changes (range 1..15)
TIMEOUT_CYCLES, 200000, max clk cycles between sample strobes inside a frame before abort (2 ms at 100 MHz)

Ports:
clk  input  1  system clock (100 MHz nominal)
reset  input  1  asynchronous, active-low reset; all state cleared while low
rx_enable  input  1  1 = receive; 0 = abort any frame, ignore line
keyb_clk  input  1  raw PS/2 clock (asynchronous)
keyb_data  input  1  raw PS/2 data (asynchronous)
raw_byte  output  8  last correctly framed byte, prefixes included
raw_valid  output  1  1-cycle pulse per correctly framed byte
key_code  output  8  scan code of the decoded key event
key_break  output  1  event is a release (preceded by 0xF0)
key_ext  output  1  event is extended (preceded by 0xE0)
key_valid  output  1  1-cycle pulse; key_code/key_break/key_ext valid
err  output  1  1-cycle pulse on a frame error
err_type  output  2  01 parity, 10 stop bit, 11 timeout; holds last value

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0. FSM=IDLE. Filtered clock=1. Sync flops=1. Pending flags cleared. Counters 0.
- Sync: 2-FF synchroniser on keyb_clk and keyb_data.
- Filter: count consecutive synced samples differing from the filtered level; flip the level when count reaches FILTER_LEN; reset count on any sample equal to the level.
- Sample strobe: 1-cycle pulse on the filtered 1->0 transition. Data bit = synced keyb_data in the strobe cycle.
- FSM states, each advancing on a strobe:
  - IDLE: bit=0 -> DATA, bit_cnt=0. bit=1 -> stay IDLE, no error.
  - DATA: shift in LSB first. After 8th bit -> PARITY.
  - PARITY: ok if 8 data bits + parity bit have odd count of ones. Latch result -> STOP.
  - STOP: requires bit=1. Always returns to IDLE.
- Frame result, registered in the cycle after the STOP strobe (latency 1):
  - parity bad -> err=1, err_type=01 (parity takes priority over stop).
  - else stop=0 -> err=1, err_type=10.
  - else raw_valid=1, raw_byte=byte.
- Prefix fold on a good byte:
  - 0xF0 -> set pend_break.
  - 0xE0 -> set pend_ext.
  - Neither prefix sets key_valid.
  - Any other byte -> key_valid=1, key_code=byte, key_break=pend_break, key_ext=pend_ext, same cycle as raw_valid; then clear both pend flags.
  - Repeated prefixes keep the flags set. E0 then F0 sets both.
- key_code/key_break/key_ext/raw_byte hold until the next update.
- Timeout: cycle counter cleared on every strobe and in IDLE. If FSM != IDLE and counter reaches TIMEOUT_CYCLES -> IDLE, err=1, err_type=11, pend flags cleared.
- Any error clears pend flags. No key_valid/raw_valid for an errored frame.
- rx_enable=0: FSM forced to IDLE; bit_cnt, timeout counter and pend flags cleared; no err pulse; strobes ignored. Synchroniser and filter keep running.
- A strobe in the same cycle rx_enable falls is ignored.
- Back-to-back frames: a new start bit is accepted on the first strobe after the STOP strobe.
- Async reset mid-frame: partial frame discarded, no pulses after release.

Test Plan:
- Bench drives PS/2 half-period of 20 clk cycles, data changed mid-high phase.
- reset=0 for 3 cycles with keyb_clk toggling -> all outputs 0. Release, frame 0x16 (parity 0) -> raw_valid and key_valid pulse once, 1 cycle after stop strobe; key_code=0x16, key_break=0, key_ext=0.
- Frames F0,16 -> one raw_valid per byte; single key_valid with key_code=0x16, key_break=1. Then E0,F0,74 -> key_code=0x74, key_break=1, key_ext=1; next frame 1E -> both flags 0.
- Frame 0x1E with parity bit flipped -> err=1, err_type=01, no raw_valid. Frame 0x26 with stop=0 -> err_type=10. Next good 0x25 -> key_valid, key_code=0x25.
- 2-cycle low glitches on keyb_clk (FILTER_LEN=4) during a 0x2E frame -> no extra strobes; key_code=0x2E received intact.
- Stop after 5 bits, idle > 200000 cycles -> err=1, err_type=11, FSM IDLE. F0 then timeout, then 0x16 -> key_break=0. rx_enable=0 mid-frame -> no err; next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
// Receive front end for the PS/2 keyboard path. Synchronises the raw PS/2
// clock/data lines, removes short glitches from the clock, deserialises
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and folds the
// 0xE0 / 0xF0 prefixes into flags so that exactly one key event is produced
// per keystroke.
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   rx_enable  1 = receive, 0 = abort any frame in progress and ignore the line
//   keyb_clk   raw PS/2 clock (asynchronous)
//   keyb_data  raw PS/2 data  (asynchronous)
//   raw_byte   last correctly framed byte, prefixes included
//   raw_valid  1-cycle pulse per correctly framed byte
//   key_code   scan code of the last key event
//   key_break  last key event was a release (F0 prefix seen)
//   key_ext    last key event was extended (E0 prefix seen)
//   key_valid  1-cycle pulse, key_code/key_break/key_ext updated
//   err        1-cycle pulse on a frame error
//   err_type   01 parity, 10 stop bit, 11 timeout; holds last value
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | waiting for a start bit (0) on a sample strobe
// S_DATA   | shifting in the 8 data bits, LSB first
// S_PARITY | capturing the parity bit, latching parity check
// S_STOP   | capturing the stop bit, issuing the frame result

module ps2_rx_frame #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       keyb_clk,
    input  logic       keyb_data,
    output logic [7:0] raw_byte,
    output logic       raw_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid,
    output logic       err,
    output logic [1:0] err_type
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_STOP    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // synchroniser and clock filter
    logic       clk_s1, clk_s2;
    logic       dat_s1, dat_s2;
    logic       filt_clk, filt_clk_d;
    logic [3:0] filt_cnt;
    logic       strobe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            filt_cnt   <= 4'd0;
        end else begin
            clk_s1     <= keyb_clk;
            clk_s2     <= clk_s1;
            dat_s1     <= keyb_data;
            dat_s2     <= dat_s1;
            filt_clk_d <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= 4'd0;
            end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
                // FILTER_LEN-th consecutive differing sample: accept new level
                filt_clk <= clk_s2;
                filt_cnt <= 4'd0;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
        end
    end

    // one-cycle pulse on the filtered falling edge
    assign strobe = filt_clk_d & ~filt_clk;

    // frame FSM
    logic [1:0]      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            parity_ok;
    logic            pend_break;
    logic            pend_ext;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            parity_ok  <= 1'b0;
            pend_break <= 1'b0;
            pend_ext   <= 1'b0;
            to_cnt     <= '0;
            raw_byte   <= 8'd0;
            raw_valid  <= 1'b0;
            key_code   <= 8'd0;
            key_break  <= 1'b0;
            key_ext    <= 1'b0;
            key_valid  <= 1'b0;
            err        <= 1'b0;
            err_type   <= 2'b00;
        end else begin
            raw_valid <= 1'b0;
            key_valid <= 1'b0;
            err       <= 1'b0;

            if (!rx_enable) begin
                // silent abort; a strobe in this cycle is dropped as well
                state      <= S_IDLE;
                bit_cnt    <= 3'd0;
                to_cnt     <= '0;
                pend_break <= 1'b0;
                pend_ext   <= 1'b0;
            end else if (strobe) begin
                to_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        // odd parity: data plus parity bit must XOR to 1
                        parity_ok <= ^{shift, dat_s2};
                        state     <= S_STOP;
                    end
                    default: begin
                        state <= S_IDLE;
                        if (!parity_ok) begin
                            err        <= 1'b1;
                            err_type   <= ERR_PARITY;
                            pend_break <= 1'b0;
                            pend_ext   <= 1'b0;
                        end else if (!dat_s2) begin
                            err        <= 1'b1;
                            err_type   <= ERR_STOP;
                            pend_break <= 1'b0;
                            pend_ext   <= 1'b0;
                        end else begin
                            raw_valid <= 1'b1;
                            raw_byte  <= shift;
                            if (shift == 8'hF0) begin
                                pend_break <= 1'b1;
                            end else if (shift == 8'hE0) begin
                                pend_ext <= 1'b1;
                            end else begin
                                key_valid  <= 1'b1;
                                key_code   <= shift;
                                key_break  <= pend_break;
                                key_ext    <= pend_ext;
                                pend_break <= 1'b0;
                                pend_ext   <= 1'b0;
                            end
                        end
                    end
                endcase
            end else if (state == S_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                // device stopped clocking mid-frame
                state      <= S_IDLE;
                bit_cnt    <= 3'd0;
                to_cnt     <= '0;
                err        <= 1'b1;
                err_type   <= ERR_TIMEOUT;
                pend_break <= 1'b0;
                pend_ext   <= 1'b0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
module tb_ps2_rx_frame;

    localparam int TO_CYC = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_enable;
    logic       keyb_clk;
    logic       keyb_data;
    logic [7:0] raw_byte;
    logic       raw_valid;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       key_valid;
    logic       err;
    logic [1:0] err_type;

    ps2_rx_frame #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_enable (rx_enable),
        .keyb_clk  (keyb_clk),
        .keyb_data (keyb_data),
        .raw_byte  (raw_byte),
        .raw_valid (raw_valid),
        .key_code  (key_code),
        .key_break (key_break),
        .key_ext   (key_ext),
        .key_valid (key_valid),
        .err       (err),
        .err_type  (err_type)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // pulse monitor
    int         raw_cnt = 0, key_cnt = 0, err_cnt = 0;
    logic [7:0] last_raw = 0, last_code = 0;
    logic       last_brk = 0, last_ext = 0;
    logic [1:0] last_et = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (raw_valid) begin raw_cnt++; last_raw = raw_byte; end
            if (key_valid) begin
                key_cnt++; last_code = key_code; last_brk = key_break; last_ext = key_ext;
            end
            if (err) begin err_cnt++; last_et = err_type; end
        end
    end

    int lat;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one PS/2 bit: 20-cycle high phase (data changes mid-high), 20-cycle low
    task automatic send_bit(input logic b, input bit glitch);
        keyb_clk = 1'b1;
        if (glitch) begin
            cyc(4); keyb_clk = 1'b0;
            cyc(2); keyb_clk = 1'b1;
            cyc(4);
        end else begin
            cyc(10);
        end
        keyb_data = b;
        cyc(10);
        keyb_clk = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (lat == 0 && (raw_valid || err)) lat = i;
        end
        cyc(8);
        keyb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit glitch);
        logic [10:0] fr;
        fr = {stop, (~^b) ^ bad_par, b, 1'b0};
        lat = 0;
        for (int i = 0; i < 11; i++) send_bit(fr[i], glitch);
        keyb_data = 1'b1;
        cyc(30);
    endtask

    task automatic send_partial(input int n);
        logic [10:0] fr;
        fr = {2'b11, 8'h55, 1'b0};
        for (int i = 0; i < n; i++) send_bit(fr[i], 1'b0);
        keyb_data = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rx_enable = 1'b1; keyb_clk = 1'b1; keyb_data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; keyb_clk = ~keyb_clk; keyb_data = ~keyb_data;
        end
        @(negedge clk);
        chk("reset_outputs", {raw_byte, raw_valid, key_code, key_break, key_ext, key_valid, err, err_type}, 0);
        keyb_clk = 1'b1; keyb_data = 1'b1;
        cyc(10);
        reset = 1'b1;
        cyc(50);

        send_frame(8'h16, 0, 1, 0);
        chk("first_raw_cnt", raw_cnt, 1);
        chk("first_key_cnt", key_cnt, 1);
        chk("first_code", last_code, 8'h16);
        chk("first_flags", {last_brk, last_ext}, 2'b00);
        chk("first_raw_byte", raw_byte, 8'h16);
        chk("first_latency", lat, 7);

        send_frame(8'hF0, 0, 1, 0);
        chk("f0_raw", last_raw, 8'hF0);
        chk("f0_no_key", key_cnt, 1);
        send_frame(8'h16, 0, 1, 0);
        chk("brk_raw_cnt", raw_cnt, 3);
        chk("brk_key_cnt", key_cnt, 2);
        chk("brk_code_flags", {last_code, last_brk, last_ext}, {8'h16, 2'b10});

        send_frame(8'hE0, 0, 1, 0);
        send_frame(8'hF0, 0, 1, 0);
        send_frame(8'h74, 0, 1, 0);
        chk("ext_raw_cnt", raw_cnt, 6);
        chk("ext_key_cnt", key_cnt, 3);
        chk("ext_code_flags", {last_code, last_brk, last_ext}, {8'h74, 2'b11});
        chk("ext_port_flags", {key_code, key_break, key_ext}, {8'h74, 2'b11});

        send_frame(8'h1E, 0, 1, 0);
        chk("clr_code_flags", {last_code, last_brk, last_ext}, {8'h1E, 2'b00});

        send_frame(8'h1E, 1, 1, 0);
        chk("par_err_cnt", err_cnt, 1);
        chk("par_err_type", last_et, 2'b01);
        chk("par_no_raw", raw_cnt, 7);
        chk("par_err_latency", lat, 7);

        send_frame(8'h26, 0, 0, 0);
        chk("stop_err_cnt", err_cnt, 2);
        chk("stop_err_type", last_et, 2'b10);
        chk("stop_hold_type", err_type, 2'b10);
        chk("stop_no_raw", raw_cnt, 7);

        send_frame(8'h25, 0, 1, 0);
        chk("after_err_key", {key_cnt[7:0], last_code}, {8'd5, 8'h25});

        send_frame(8'h2E, 0, 1, 1);
        chk("glitch_key", {key_cnt[7:0], last_code}, {8'd6, 8'h2E});
        chk("glitch_raw_cnt", raw_cnt, 9);
        chk("glitch_err_cnt", err_cnt, 2);

        send_partial(5);
        cyc(TO_CYC + 200);
        chk("timeout_err_cnt", err_cnt, 3);
        chk("timeout_type", last_et, 2'b11);
        send_frame(8'h16, 0, 1, 0);
        chk("post_to_key", {key_cnt[7:0], last_code}, {8'd7, 8'h16});

        send_frame(8'hF0, 0, 1, 0);
        send_partial(5);
        cyc(TO_CYC + 200);
        chk("f0_timeout_err", err_cnt, 4);
        send_frame(8'h16, 0, 1, 0);
        chk("f0_to_cleared", {key_cnt[7:0], last_code, last_brk}, {8'd8, 8'h16, 1'b0});

        send_partial(5);
        rx_enable = 1'b0;
        cyc(50);
        rx_enable = 1'b1;
        cyc(TO_CYC + 200);
        chk("disable_no_err", err_cnt, 4);
        send_frame(8'h1C, 0, 1, 0);
        chk("disable_then_key", {key_cnt[7:0], last_code}, {8'd9, 8'h1C});

        send_frame(8'hF0, 0, 1, 0);
        send_partial(5);
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(TO_CYC + 200);
        chk("rst_mid_no_pulse", {raw_cnt[7:0], key_cnt[7:0], err_cnt[7:0]}, {8'd14, 8'd9, 8'd4});
        send_frame(8'h32, 0, 1, 0);
        chk("rst_mid_key", {key_cnt[7:0], last_code, last_brk}, {8'd10, 8'h32, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
